// File: rtl/stream_frame_rx.sv
// Pixel stream receiver: locks onto frame boundaries, checks sof/eol framing
// against a tracked raster position and forwards pixels with recovered x/y.
module stream_frame_rx #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  parameter int DATA_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  input  logic                s_sof,
  input  logic                s_eol,
  output logic                s_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic signed [15:0]  m_x,
  output logic signed [15:0]  m_y,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                frame_done,
  output logic                locked,
  output logic [15:0]         err_count
);

  localparam int XMIN_I = -(X_SIZE / 2);
  localparam int XMAX_I = X_SIZE / 2 - 1;
  localparam int YMAX_I = Y_SIZE / 2;
  localparam int YMIN_I = 1 - Y_SIZE / 2;

  localparam logic signed [15:0] X_MIN = 16'(XMIN_I);
  localparam logic signed [15:0] X_MAX = 16'(XMAX_I);
  localparam logic signed [15:0] Y_MAX = 16'(YMAX_I);
  localparam logic signed [15:0] Y_MIN = 16'(YMIN_I);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t state;

  logic signed [15:0] ex, ey;
  logic signed [15:0] bx, by;
  logic signed [15:0] ax, ay;
  logic accept, exp_sof, exp_eol;
  logic fwd, restart, err, go_hunt;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign locked  = (state == LOCKED);
  assign exp_sof = (ex == X_MIN) && (ey == Y_MAX);
  assign exp_eol = (ex == X_MAX);

  always_comb begin
    fwd     = 1'b0;
    restart = 1'b0;
    err     = 1'b0;
    go_hunt = 1'b0;
    if (state == HUNT) begin
      if (s_sof && !s_eol) begin
        fwd     = 1'b1;
        restart = 1'b1;
      end else if (s_sof) begin
        err = 1'b1;
      end
    end else begin
      unique case (1'b1)
        s_sof && !s_eol: begin
          fwd     = 1'b1;
          restart = 1'b1;
          err     = !exp_sof;
        end
        s_sof && s_eol: begin
          err     = 1'b1;
          go_hunt = 1'b1;
        end
        !s_sof && (exp_sof || (s_eol != exp_eol)): begin
          err     = 1'b1;
          go_hunt = 1'b1;
        end
        default: fwd = 1'b1;
      endcase
    end
  end

  // Forwarded position, and the position that follows it in raster order.
  always_comb begin
    bx = restart ? X_MIN : ex;
    by = restart ? Y_MAX : ey;
    if (bx == X_MAX) begin
      ax = X_MIN;
      ay = (by == Y_MIN) ? Y_MAX : by - 16'sd1;
    end else begin
      ax = bx + 16'sd1;
      ay = by;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      ex         <= X_MIN;
      ey         <= Y_MAX;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_x        <= '0;
      m_y        <= '0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      frame_done <= accept && fwd && (bx == X_MAX) && (by == Y_MIN);
      if (accept && fwd) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_x     <= bx;
        m_y     <= by;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept) begin
        if (err && (err_count != 16'hFFFF))
          err_count <= err_count + 16'd1;
        if (fwd) begin
          state <= LOCKED;
          ex    <= ax;
          ey    <= ay;
        end else if (go_hunt) begin
          state <= HUNT;
          ex    <= X_MIN;
          ey    <= Y_MAX;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_frame_rx.sv
// Scoreboard bench for stream_frame_rx: directed framing cases followed by
// randomized corrupted streams with random backpressure.
module tb_stream_frame_rx;

  localparam int XS = 4;
  localparam int YS = 2;
  localparam int DW = 24;
  localparam int N  = XS * YS;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [DW-1:0]       s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_sof = 1'b0;
  logic                s_eol = 1'b0;
  logic                s_ready;
  logic [DW-1:0]       m_data;
  logic signed [15:0]  m_x;
  logic signed [15:0]  m_y;
  logic                m_valid;
  logic                m_ready = 1'b1;
  logic                frame_done;
  logic                locked;
  logic [15:0]         err_count;

  stream_frame_rx #(.X_SIZE(XS), .Y_SIZE(YS), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_eol(s_eol),
    .s_ready(s_ready),
    .m_data(m_data), .m_x(m_x), .m_y(m_y), .m_valid(m_valid),
    .m_ready(m_ready),
    .frame_done(frame_done), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            x;
    int            y;
  } beat_t;

  beat_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model: frame position as a linear pixel index.
  bit m_locked = 1'b0;
  int m_pos = 0;
  int m_err = 0;
  bit exp_mv = 1'b0;
  bit exp_fd = 1'b0;
  bit rdy_rand = 1'b0;
  int stall = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic void bump_err();
    if (m_err < 65535) m_err++;
  endfunction

  function automatic void emit(input int p, input logic [DW-1:0] d);
    beat_t b;
    b.d = d;
    b.x = -(XS / 2) + p % XS;
    b.y = YS / 2 - p / XS;
    sb.push_back(b);
    if (p == N - 1) exp_fd = 1'b1;
  endfunction

  function automatic bit model_beat(input bit sof, input bit eol,
                                    input logic [DW-1:0] d);
    bit e_sof, e_eol;
    if (!m_locked) begin
      if (sof && !eol) begin
        emit(0, d);
        m_pos = 1;
        m_locked = 1'b1;
        return 1'b1;
      end
      if (sof) bump_err();
      return 1'b0;
    end
    e_sof = (m_pos == 0);
    e_eol = (m_pos % XS == XS - 1);
    if (sof && !eol) begin
      if (!e_sof) bump_err();
      emit(0, d);
      m_pos = 1;
      return 1'b1;
    end
    if (sof || e_sof || (eol != e_eol)) begin
      bump_err();
      m_locked = 1'b0;
      m_pos = 0;
      return 1'b0;
    end
    emit(m_pos, d);
    m_pos = (m_pos + 1) % N;
    return 1'b1;
  endfunction

  task automatic cycle(input bit rst, input bit v, input bit sof,
                       input bit eol, output bit acc);
    logic [DW-1:0] d;
    bit rdy, sready, fwd;
    @(negedge clk);
    rdy = (stall > 0) ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (stall > 0) stall--;
    d = DW'($urandom);
    reset = rst;
    s_valid = v;
    s_sof = sof;
    s_eol = eol;
    s_data = d;
    m_ready = rdy;
    #1;
    sready = !exp_mv || rdy;
    check("s_ready", s_ready, sready);
    acc = 1'b0;
    fwd = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_pos = 0;
      m_err = 0;
      exp_mv = 1'b0;
      exp_fd = 1'b0;
      sb.delete();
    end else begin
      if (v && sready) begin
        acc = 1'b1;
        fwd = model_beat(sof, eol, d);
      end
      exp_mv = fwd ? 1'b1 : (rdy ? 1'b0 : exp_mv);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, acc);
    check("reset_m_data", m_data, 0);
    check("reset_m_x", $signed(m_x), 0);
    check("reset_m_y", $signed(m_y), 0);
    check("reset_m_valid", m_valid, 0);
  endtask

  task automatic send_beat(input bit sof, input bit eol);
    bit acc;
    int n;
    if (rdy_rand) idle($urandom_range(0, 2));
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      cycle(1'b0, 1'b1, sof, eol, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept required accept");
    end
  endtask

  task automatic send_frame();
    for (int p = 0; p < N; p++) send_beat(p == 0, (p % XS) == XS - 1);
  endtask

  // Registered status, checked just after each active edge.
  always begin
    @(posedge clk);
    #1;
    check("err_count", err_count, m_err);
    check("locked", locked, m_locked);
    check("frame_done", frame_done, exp_fd);
    check("m_valid", m_valid, exp_mv);
    exp_fd = 1'b0;
  end

  // Output monitor: pops the scoreboard on each downstream handshake.
  logic [DW-1:0] h_d;
  logic signed [15:0] h_x, h_y;
  bit hold = 1'b0;
  always begin
    beat_t b;
    @(negedge clk);
    #2;
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold && m_valid) begin
        check("hold_data", m_data, h_d);
        check("hold_x", $signed(m_x), $signed(h_x));
        check("hold_y", $signed(m_y), $signed(h_y));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got beat x=%0d y=%0d required none",
                   m_x, m_y);
        end else begin
          b = sb.pop_front();
          check("out_data", m_data, b.d);
          check("out_x", $signed(m_x), b.x);
          check("out_y", $signed(m_y), b.y);
        end
      end
      hold = m_valid && !m_ready;
      h_d = m_data;
      h_x = m_x;
      h_y = m_y;
    end
  end

  initial begin
    int gp;
    bit sof, eol;
    int r;
    do_reset();
    // clean frame
    send_frame();
    idle(3);
    // junk before first sof
    do_reset();
    for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0);
    send_frame();
    idle(2);
    // early sof at (0,1)
    do_reset();
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b1, 1'b0);
    for (int p = 1; p < N; p++) send_beat(1'b0, (p % XS) == XS - 1);
    idle(2);
    // missing eol at x=1, then relock
    do_reset();
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    send_frame();
    idle(2);
    // backpressure
    send_beat(1'b1, 1'b0);
    stall = 5;
    for (int p = 1; p < N; p++) send_beat(1'b0, (p % XS) == XS - 1);
    idle(3);
    // reset mid-frame
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    do_reset();
    send_frame();
    send_frame();
    idle(2);
    // randomized corrupted stream
    rdy_rand = 1'b1;
    gp = 0;
    for (int i = 0; i < 400; i++) begin
      sof = (gp == 0);
      eol = (gp % XS) == XS - 1;
      r = $urandom_range(0, 19);
      if (r == 0) sof = !sof;
      if (r == 1) eol = !eol;
      if (r == 2) gp = (gp + 1) % N;
      else begin
        send_beat(sof, eol);
        gp = (gp + 1) % N;
      end
      if (i % 150 == 149) do_reset();
    end
    rdy_rand = 1'b0;
    idle(5);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
